// File: rtl/alu_pkg.sv
// alu_ext shared definitions: opcode fields and FSM state encoding.
// Imported by alu_ext and prio_slice.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [4:0] OP_PFIND = 5'b10000;
  localparam logic [4:0] OP_PCLR  = 5'b10001;

  localparam int OP_ALT_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/prio_slice.sv
// Lowest-set-bit encoder over one SLICE-bit window of the masked vector.
// Scanning from the top lets the lowest set bit win.
module prio_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8,
  parameter int SW    = (SLICE > 1) ? $clog2(SLICE) : 1
) (
  input  logic [SLICE-1:0] vec,
  output logic             hit,
  output logic [SW-1:0]    idx
);

  always_comb begin
    idx = '0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (vec[i]) idx = SW'(i);
    end
  end

  assign hit = |vec;

endmodule

// File: rtl/alu_ext.sv
// Handshaked execute-stage ALU: registered basic ops, and a
// slice-by-slice priority find/clear scan with early exit.
module alu_ext
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 8,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic [TAGW-1:0] req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [TAGW-1:0] resp_tag
);

  localparam int LW = $clog2(XLEN);
  localparam int NS = XLEN / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam int SW = (SLICE > 1) ? $clog2(SLICE) : 1;

  state_t            state, state_n;
  logic [KW-1:0]     k;
  logic [XLEN-1:0]   m_q, op1_q;
  logic              clr_q;
  logic              accept, prio, alt, last;
  logic [LW-1:0]     sa, pos;
  logic [XLEN-1:0]   basic, scan_res;
  logic [SLICE-1:0]  sl_vec;
  logic              sl_hit;
  logic [SW-1:0]     sl_idx;

  assign req_ready  = (state == ST_IDLE) ||
                      (state == ST_RESP && resp_ready);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  assign prio       = (req_op[4] == OP_PFIND[4]);
  assign alt        = req_op[OP_ALT_BIT];
  assign sa         = req_op2[LW-1:0];
  assign last       = (k == KW'(NS - 1));

  always_comb begin
    basic = '0;
    unique case (req_op[2:0])
      OP_ADD:  basic = alt ? req_op1 - req_op2
                           : req_op1 + req_op2;
      OP_SLL:  basic = req_op1 << sa;
      OP_SLT:  basic = XLEN'($signed(req_op1) <
                             $signed(req_op2));
      OP_SLTU: basic = XLEN'(req_op1 < req_op2);
      OP_XOR:  basic = alt ? XLEN'(req_op1 == req_op2)
                           : req_op1 ^ req_op2;
      // kept as if/else: a ?: would make >>> unsigned
      OP_SRL: begin
        if (alt) basic = $signed(req_op1) >>> sa;
        else     basic = req_op1 >> sa;
      end
      OP_OR:   basic = req_op1 | req_op2;
      OP_AND:  basic = req_op1 & req_op2;
      default: basic = '0;
    endcase
  end

  assign sl_vec = m_q[int'(k)*SLICE +: SLICE];

  prio_slice #(.SLICE(SLICE), .SW(SW)) u_slice (
    .vec (sl_vec),
    .hit (sl_hit),
    .idx (sl_idx)
  );

  assign pos = LW'(k) * LW'(SLICE) + LW'(sl_idx);

  always_comb begin
    if (sl_hit)
      scan_res = clr_q ? op1_q & ~(XLEN'(1) << pos)
                       : XLEN'(pos);
    else
      scan_res = clr_q ? op1_q
                       : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_n = prio ? ST_SCAN : ST_RESP;
      ST_SCAN:
        if (sl_hit || last) state_n = ST_RESP;
      ST_RESP:
        if (resp_ready)
          state_n = !accept ? ST_IDLE
                  : prio    ? ST_SCAN : ST_RESP;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      k           <= '0;
      m_q         <= '0;
      op1_q       <= '0;
      clr_q       <= 1'b0;
      resp_result <= '0;
      resp_tag    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        k        <= '0;
        m_q      <= req_op1 & ~req_op2;
        op1_q    <= req_op1;
        clr_q    <= (req_op[0] == OP_PCLR[0]);
        resp_tag <= req_tag;
        if (!prio) resp_result <= basic;
      end else if (state == ST_SCAN) begin
        if (sl_hit || last) resp_result <= scan_res;
        else                k <= k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_ext.sv
// Directed self-checking bench for alu_ext (XLEN=32, SLICE=8).
// Vector table plus hand-written handshake and reset sequences.
module tb_alu_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [5:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [5:0]  resp_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  alu_ext #(.XLEN(32), .SLICE(8), .TAGW(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_tag    (resp_tag)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_op1   = v.a;
    req_op2   = v.b;
    req_tag   = v.tag;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, " accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " result"}, resp_result, v.exp);
    chk({v.name, " tag"}, 32'(resp_tag), 32'(v.tag));
  endtask

  initial begin
    int seen;

    vecs[0]  = '{"add",   5'b00000, 32'd5, 32'd7, 6'd1, 32'h0000000C, 1};
    vecs[1]  = '{"sub",   5'b01000, 32'd3, 32'd5, 6'd2, 32'hFFFFFFFE, 1};
    vecs[2]  = '{"sra",   5'b01101, 32'h80000000, 32'd4, 6'd3, 32'hF8000000, 1};
    vecs[3]  = '{"srl",   5'b00101, 32'h80000000, 32'd4, 6'd4, 32'h08000000, 1};
    vecs[4]  = '{"slt",   5'b00010, 32'hFFFFFFFF, 32'd1, 6'd5, 32'd1, 1};
    vecs[5]  = '{"sltu",  5'b00011, 32'hFFFFFFFF, 32'd1, 6'd6, 32'd0, 1};
    vecs[6]  = '{"seq",   5'b01100, 32'h1234ABCD, 32'h1234ABCD, 6'd7, 32'd1, 1};
    vecs[7]  = '{"sne",   5'b01100, 32'd5, 32'd6, 6'd8, 32'd0, 1};
    vecs[8]  = '{"xor",   5'b00100, 32'hFF00FF00, 32'h0FF00FF0, 6'd9, 32'hF0F0F0F0, 1};
    vecs[9]  = '{"or",    5'b00110, 32'h0000000F, 32'h000000F0, 6'd10, 32'h000000FF, 1};
    vecs[10] = '{"and",   5'b00111, 32'h0000FF00, 32'h00000FF0, 6'd11, 32'h00000F00, 1};
    vecs[11] = '{"sll_sa", 5'b00001, 32'd1, 32'h00000021, 6'd12, 32'd2, 1};
    vecs[12] = '{"sll31", 5'b00001, 32'd1, 32'd31, 6'd13, 32'h80000000, 1};
    vecs[13] = '{"find16", 5'b10000, 32'h00010000, 32'd0, 6'd14, 32'h00000010, 4};
    vecs[14] = '{"clr11", 5'b10001, 32'h00000C00, 32'h00000400, 6'd15, 32'h00000400, 3};
    vecs[15] = '{"find_nf", 5'b10000, 32'hFFFF0000, 32'hFFFF0000, 6'd16, 32'h80000000, 5};
    vecs[16] = '{"clr_nf", 5'b10001, 32'hFFFF0000, 32'hFFFF0000, 6'd17, 32'hFFFF0000, 5};
    vecs[17] = '{"find31", 5'b11110, 32'h80000000, 32'd0, 6'd18, 32'h0000001F, 5};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_result", resp_result, 32'd0);
    chk("reset resp_tag", 32'(resp_tag), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // find on bit 0 with op[3:1] set, and clear of bit 0
    run_vec('{"find0", 5'b11110, 32'd1, 32'd0, 6'd19, 32'd0, 2});
    run_vec('{"clr0", 5'b10001, 32'hFFFFFFFF, 32'd0, 6'd20, 32'hFFFFFFFE, 2});

    // back-to-back basic ops
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'b00000; req_op1 = 32'd5; req_op2 = 32'd7; req_tag = 6'd33;
    chk("b2b ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b valid1", 32'(resp_valid), 32'd1);
    chk("b2b result1", resp_result, 32'h0000000C);
    chk("b2b tag1", 32'(resp_tag), 32'd33);
    req_op = 5'b01000; req_op1 = 32'd3; req_op2 = 32'd5; req_tag = 6'd34;
    #1;
    chk("b2b ready1", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b valid2", 32'(resp_valid), 32'd1);
    chk("b2b result2", resp_result, 32'hFFFFFFFE);
    chk("b2b tag2", 32'(resp_tag), 32'd34);
    chk("b2b ready2", 32'(req_ready), 32'd1);
    req_valid = 1'b0;

    // stalled response with a pending request behind it
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = 5'b00000; req_op1 = 32'd1; req_op2 = 32'd1; req_tag = 6'd9;
    @(negedge clk);
    chk("stall valid", 32'(resp_valid), 32'd1);
    chk("stall result0", resp_result, 32'd2);
    req_op = 5'b00110; req_op1 = 32'hF0; req_op2 = 32'h0F; req_tag = 6'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall result", resp_result, 32'd2);
      chk("stall tag", 32'(resp_tag), 32'd9);
      chk("stall req_ready", 32'(req_ready), 32'd0);
      chk("stall resp_valid", 32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    chk("unstall req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("unstall valid", 32'(resp_valid), 32'd1);
    chk("unstall result", resp_result, 32'h000000FF);
    chk("unstall tag", 32'(resp_tag), 32'd10);

    // reset in the middle of a scan
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'b10000; req_op1 = 32'h80000000; req_op2 = 32'd0;
    req_tag = 6'h2A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstscan valid1", 32'(resp_valid), 32'd0);
    chk("rstscan ready1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rstscan valid2", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstscan resp_valid", 32'(resp_valid), 32'd0);
    chk("rstscan resp_result", resp_result, 32'd0);
    chk("rstscan resp_tag", 32'(resp_tag), 32'd0);
    chk("rstscan req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rstscan no response", 32'(seen), 32'd0);
    run_vec('{"post_rst_add", 5'b00000, 32'd100, 32'd23, 6'd5, 32'd123, 1});

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
